addr_channel_arbiter: RTL and testbench

//  Merges the AXI read-address (AR) and write-address (AW) channels into a single request

---
 rtl/addr_channel_arbiter_if.sv | 31 +++
 rtl/addr_channel_arbiter.sv | 104 ++++++++++
 tb/tb_addr_channel_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/addr_channel_arbiter_if.sv
// rtl/addr_channel_arbiter_if.sv - AR/AW request, merged output and flush signals of the address channel arbiter
interface addr_channel_arbiter_if #(
    parameter int ID_W   = 32,
    parameter int ADDR_W = 32
);
    logic [ID_W-1:0]   arid_i;
    logic [ADDR_W-1:0] araddr_i;
    logic              arvalid_i;
    logic              arready_o;
    logic [ID_W-1:0]   awid_i;
    logic [ADDR_W-1:0] awaddr_i;
    logic              awvalid_i;
    logic              awready_o;
    logic              out_valid_o;
    logic              out_write_o;
    logic [ID_W-1:0]   out_id_o;
    logic [ADDR_W-1:0] out_addr_o;
    logic              out_ready_i;
    logic              flush_i;
    logic              flush_done_o;

    modport slave (
        input  arid_i, araddr_i, arvalid_i, awid_i, awaddr_i, awvalid_i, out_ready_i, flush_i,
        output arready_o, awready_o, out_valid_o, out_write_o, out_id_o, out_addr_o, flush_done_o
    );

    modport master (
        output arid_i, araddr_i, arvalid_i, awid_i, awaddr_i, awvalid_i, out_ready_i, flush_i,
        input  arready_o, awready_o, out_valid_o, out_write_o, out_id_o, out_addr_o, flush_done_o
    );
endinterface

// File: rtl/addr_channel_arbiter.sv
// rtl/addr_channel_arbiter.sv - read-priority AR/AW merge with write-starvation limit and flush/drain
module addr_channel_arbiter #(
    parameter int ID_W          = 32,
    parameter int ADDR_W        = 32,
    parameter int WR_STARVE_MAX = 4
) (
    input logic                   clk,
    input logic                   rst,
    addr_channel_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(WR_STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(WR_STARVE_MAX);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]        state;
    logic [CNT_W-1:0]  starve_cnt;
    logic              out_valid;
    logic              out_write;
    logic [ID_W-1:0]   out_id;
    logic [ADDR_W-1:0] out_addr;

    logic can_load;
    logic grant_rd;
    logic grant_wr;
    logic ar_acc;
    logic aw_acc;

    // rst gates the readies so nothing is accepted while reset is held
    always_comb begin
        can_load = !rst && (state == ST_RUN) && (!out_valid || bus.out_ready_i);
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (bus.arvalid_i && bus.awvalid_i) begin
            grant_wr = (starve_cnt == STARVE_LIMIT);
            grant_rd = !grant_wr;
        end else begin
            grant_rd = bus.arvalid_i;
            grant_wr = bus.awvalid_i;
        end
        ar_acc = can_load && grant_rd;
        aw_acc = can_load && grant_wr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_write <= 1'b0;
            out_id    <= '0;
            out_addr  <= '0;
        end else if (ar_acc) begin
            out_valid <= 1'b1;
            out_write <= 1'b0;
            out_id    <= bus.arid_i;
            out_addr  <= bus.araddr_i;
        end else if (aw_acc) begin
            out_valid <= 1'b1;
            out_write <= 1'b1;
            out_id    <= bus.awid_i;
            out_addr  <= bus.awaddr_i;
        end else if (bus.out_ready_i) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!bus.awvalid_i || aw_acc) begin
            starve_cnt <= '0;
        end else if (ar_acc && (starve_cnt != STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Dropping flush in DRAIN returns to RUN; the buffered request drains normally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:   if (bus.flush_i) state <= ST_DRAIN;
                ST_DRAIN: begin
                    if (!bus.flush_i)
                        state <= ST_RUN;
                    else if (!out_valid || bus.out_ready_i)
                        state <= ST_DONE;
                end
                ST_DONE:  if (!bus.flush_i) state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

    assign bus.arready_o    = ar_acc;
    assign bus.awready_o    = aw_acc;
    assign bus.out_valid_o  = out_valid;
    assign bus.out_write_o  = out_write;
    assign bus.out_id_o     = out_id;
    assign bus.out_addr_o   = out_addr;
    assign bus.flush_done_o = (state == ST_DONE);
endmodule

// File: tb/tb_addr_channel_arbiter.sv
// tb/tb_addr_channel_arbiter.sv - directed self-checking bench for addr_channel_arbiter
module tb_addr_channel_arbiter;
    localparam int ID_W   = 32;
    localparam int ADDR_W = 32;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    addr_channel_arbiter_if #(.ID_W(ID_W), .ADDR_W(ADDR_W)) bus ();

    addr_channel_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .WR_STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.arid_i = '0; bus.araddr_i = '0; bus.arvalid_i = 1'b1;
        bus.awid_i = '0; bus.awaddr_i = '0; bus.awvalid_i = 1'b0;
        bus.out_ready_i = 1'b0; bus.flush_i = 1'b0;

        // reset held for three cycles with a read pending
        repeat (3) step();
        check("rst_arready", bus.arready_o, 0);
        check("rst_out_valid", bus.out_valid_o, 0);
        check("rst_out_write", bus.out_write_o, 0);
        check("rst_out_id", bus.out_id_o, 0);
        check("rst_out_addr", bus.out_addr_o, 0);
        check("rst_flush_done", bus.flush_done_o, 0);

        // single read
        rst = 1'b0;
        bus.araddr_i = 32'h40; bus.arid_i = 3; bus.out_ready_i = 1'b1;
        #1;
        check("rd_arready", bus.arready_o, 1);
        check("rd_awready", bus.awready_o, 0);
        step();
        bus.arvalid_i = 1'b0;
        #1;
        check("rd_valid", bus.out_valid_o, 1);
        check("rd_write", bus.out_write_o, 0);
        check("rd_id", bus.out_id_o, 3);
        check("rd_addr", bus.out_addr_o, 32'h40);
        check("rd_arready_low", bus.arready_o, 0);
        step();
        check("rd_consumed", bus.out_valid_o, 0);

        // starvation: R,R,R,R,W repeating
        bus.arvalid_i = 1'b1; bus.awvalid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.araddr_i = 32'h1000 + i; bus.awaddr_i = 32'h2000 + i;
            #1;
            check($sformatf("starve_aw%0d", i), bus.awready_o, (i % 5) == 4);
            check($sformatf("starve_ar%0d", i), bus.arready_o, (i % 5) != 4);
            step();
            check($sformatf("starve_wr%0d", i), bus.out_write_o, (i % 5) == 4);
            check($sformatf("starve_addr%0d", i), bus.out_addr_o,
                  ((i % 5) == 4) ? 32'h2000 + i : 32'h1000 + i);
        end
        bus.arvalid_i = 1'b0; bus.awvalid_i = 1'b0;
        step();
        check("starve_drained", bus.out_valid_o, 0);

        // backpressure then back-to-back release
        bus.arvalid_i = 1'b1; bus.araddr_i = 32'h100; bus.arid_i = 5; bus.out_ready_i = 1'b0;
        #1;
        check("bp_first_accept", bus.arready_o, 1);
        step();
        bus.araddr_i = 32'h200; bus.arid_i = 6;
        bus.awvalid_i = 1'b1; bus.awaddr_i = 32'h300; bus.awid_i = 7;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp_arready%0d", i), bus.arready_o, 0);
            check($sformatf("bp_awready%0d", i), bus.awready_o, 0);
            check($sformatf("bp_addr%0d", i), bus.out_addr_o, 32'h100);
            check($sformatf("bp_id%0d", i), bus.out_id_o, 5);
            step();
        end
        bus.out_ready_i = 1'b1;
        #1;
        check("bp_rel_arready", bus.arready_o, 1);
        step();
        check("bp_rel_addr", bus.out_addr_o, 32'h200);
        check("bp_rel_id", bus.out_id_o, 6);
        bus.arvalid_i = 1'b0;
        #1;
        check("bp_rel_awready", bus.awready_o, 1);
        step();
        check("bp_wr_valid", bus.out_valid_o, 1);
        check("bp_wr_write", bus.out_write_o, 1);
        check("bp_wr_addr", bus.out_addr_o, 32'h300);
        check("bp_wr_id", bus.out_id_o, 7);
        bus.awvalid_i = 1'b0;
        step();
        check("bp_empty", bus.out_valid_o, 0);

        // flush with a buffered request
        bus.arvalid_i = 1'b1; bus.araddr_i = 32'h500; bus.arid_i = 9;
        step();
        check("fl_buffered", bus.out_valid_o, 1);
        bus.out_ready_i = 1'b0; bus.flush_i = 1'b1; bus.araddr_i = 32'h600;
        #1;
        check("fl_first_arready", bus.arready_o, 0);
        step();
        check("fl_drain_done", bus.flush_done_o, 0);
        check("fl_drain_valid", bus.out_valid_o, 1);
        check("fl_drain_addr", bus.out_addr_o, 32'h500);
        bus.out_ready_i = 1'b1;
        #1;
        check("fl_drain_arready", bus.arready_o, 0);
        step();
        check("fl_done", bus.flush_done_o, 1);
        check("fl_done_valid", bus.out_valid_o, 0);
        check("fl_done_arready", bus.arready_o, 0);
        bus.flush_i = 1'b0;
        #1;
        check("fl_release_arready", bus.arready_o, 0);
        step();
        check("fl_run_done", bus.flush_done_o, 0);
        check("fl_run_arready", bus.arready_o, 1);
        step();
        check("fl_resume_addr", bus.out_addr_o, 32'h600);

        // drive starve_cnt to the limit, then async reset mid-transfer
        bus.awvalid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("pre_rst_ar%0d", i), bus.arready_o, 1);
            step();
        end
        bus.out_ready_i = 1'b0;
        #2;
        check("pre_rst_valid", bus.out_valid_o, 1);
        rst = 1'b1;
        #1;
        check("arst_valid", bus.out_valid_o, 0);
        check("arst_addr", bus.out_addr_o, 0);
        check("arst_arready", bus.arready_o, 0);
        check("arst_awready", bus.awready_o, 0);
        bus.arvalid_i = 1'b0; bus.awvalid_i = 1'b0;
        rst = 1'b0;
        step();
        bus.arvalid_i = 1'b1; bus.awvalid_i = 1'b1; bus.out_ready_i = 1'b1;
        #1;
        check("post_rst_arready", bus.arready_o, 1);
        check("post_rst_awready", bus.awready_o, 0);
        check("post_rst_done", bus.flush_done_o, 0);
        step();
        bus.arvalid_i = 1'b0; bus.awvalid_i = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
